// File: rtl/spi_slave_if_if.sv
// Bus bundle between the SPI slave front end, the external SPI master pins
// and the single-port RAM. The master modport is the environment side
// (pins plus RAM read port); the slave modport is the front end itself.
interface spi_slave_if_if #(
  parameter int ADDR_SIZE = 8
);

  // SPI pins
  logic                 SS_n;
  logic                 MOSI;
  logic                 MISO;

  // RAM side: received command words out, read words back in
  logic [ADDR_SIZE+1:0] rx_data;
  logic                 rx_valid;
  logic [ADDR_SIZE-1:0] tx_data;
  logic                 tx_valid;

  modport slave (
    input  SS_n,
    input  MOSI,
    output MISO,
    output rx_data,
    output rx_valid,
    input  tx_data,
    input  tx_valid
  );

  modport master (
    output SS_n,
    output MOSI,
    input  MISO,
    input  rx_data,
    input  rx_valid,
    output tx_data,
    output tx_valid
  );

endinterface

// File: rtl/spi_slave_if.sv
// SPI slave front end for the single-port RAM wrapper.
// Deserialises MOSI frames (select bit + ADDR_SIZE+2 bit command word) into
// rx_data/rx_valid, and serialises the RAM's read word back out on MISO.
// Optional build macro SPI_SLAVE_ABORT_FLAG_EN adds a frame_abort output that
// pulses when SS_n rises before a frame (or a read shift-out) has completed.
module spi_slave_if #(
  parameter int ADDR_SIZE = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  spi_slave_if_if.slave bus
`ifdef SPI_SLAVE_ABORT_FLAG_EN
  ,
  output logic          frame_abort
`endif
);

  localparam int FRAME_W   = ADDR_SIZE + 2;
  localparam int BIT_CNT_W = $clog2(FRAME_W);
  localparam int TX_CNT_W  = (ADDR_SIZE > 1) ? $clog2(ADDR_SIZE) : 1;

  localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(FRAME_W - 1);
  localparam logic [TX_CNT_W-1:0]  TX_LAST  = TX_CNT_W'(ADDR_SIZE - 1);

  typedef enum logic [2:0] {
    IDLE,
    CHK_CMD,
    WRITE,
    READ_ADD,
    READ_DATA
  } state_t;

  state_t                 state_reg, state_next;
  logic [BIT_CNT_W-1:0]   bit_cnt_reg, bit_cnt_next;
  // The first FRAME_W-1 bits of a frame; the final bit goes straight into rx_data.
  logic [FRAME_W-2:0]     rx_shift_reg, rx_shift_next;
  logic [FRAME_W-1:0]     rx_data_reg, rx_data_next;
  logic                   rx_valid_reg, rx_valid_next;
  // Set once the current frame has delivered its rx_valid; later bits are ignored.
  logic                   frame_done_reg, frame_done_next;
  // Remembers that a read address has been sent, so the next read frame is READ_DATA.
  logic                   rd_addr_flag_reg, rd_addr_flag_next;
  logic [ADDR_SIZE-1:0]   tx_shift_reg, tx_shift_next;
  // Bits still to be driven after the one currently on MISO.
  logic [TX_CNT_W-1:0]    tx_cnt_reg, tx_cnt_next;
  logic                   tx_busy_reg, tx_busy_next;
  logic                   tx_done_reg, tx_done_next;
  logic                   miso_reg, miso_next;
`ifdef SPI_SLAVE_ABORT_FLAG_EN
  logic                   abort_reg, abort_next;
`endif

  // State and datapath registers, all cleared by the asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg        <= IDLE;
      bit_cnt_reg      <= '0;
      rx_shift_reg     <= '0;
      rx_data_reg      <= '0;
      rx_valid_reg     <= 1'b0;
      frame_done_reg   <= 1'b0;
      rd_addr_flag_reg <= 1'b0;
      tx_shift_reg     <= '0;
      tx_cnt_reg       <= '0;
      tx_busy_reg      <= 1'b0;
      tx_done_reg      <= 1'b0;
      miso_reg         <= 1'b0;
`ifdef SPI_SLAVE_ABORT_FLAG_EN
      abort_reg        <= 1'b0;
`endif
    end else begin
      state_reg        <= state_next;
      bit_cnt_reg      <= bit_cnt_next;
      rx_shift_reg     <= rx_shift_next;
      rx_data_reg      <= rx_data_next;
      rx_valid_reg     <= rx_valid_next;
      frame_done_reg   <= frame_done_next;
      rd_addr_flag_reg <= rd_addr_flag_next;
      tx_shift_reg     <= tx_shift_next;
      tx_cnt_reg       <= tx_cnt_next;
      tx_busy_reg      <= tx_busy_next;
      tx_done_reg      <= tx_done_next;
      miso_reg         <= miso_next;
`ifdef SPI_SLAVE_ABORT_FLAG_EN
      abort_reg        <= abort_next;
`endif
    end
  end

  // Next-state, frame shift-in, read-word shift-out and abort decisions.
  always_comb begin
    state_next        = state_reg;
    bit_cnt_next      = bit_cnt_reg;
    rx_shift_next     = rx_shift_reg;
    rx_data_next      = rx_data_reg;
    rx_valid_next     = 1'b0;
    frame_done_next   = frame_done_reg;
    rd_addr_flag_next = rd_addr_flag_reg;
    tx_shift_next     = tx_shift_reg;
    tx_cnt_next       = tx_cnt_reg;
    tx_busy_next      = tx_busy_reg;
    tx_done_next      = tx_done_reg;
    miso_next         = 1'b0;
`ifdef SPI_SLAVE_ABORT_FLAG_EN
    abort_next        = 1'b0;
`endif

    case (state_reg)
      IDLE: begin
        if (!bus.SS_n) begin
          state_next = CHK_CMD;
        end
      end

      CHK_CMD: begin
        // Start every frame from a clean slate; the select bit itself is not kept.
        bit_cnt_next    = '0;
        frame_done_next = 1'b0;
        tx_busy_next    = 1'b0;
        tx_done_next    = 1'b0;
        tx_cnt_next     = '0;
        if (bus.SS_n) begin
          state_next = IDLE;
        end else if (!bus.MOSI) begin
          state_next = WRITE;
        end else if (rd_addr_flag_reg) begin
          state_next = READ_DATA;
        end else begin
          state_next = READ_ADD;
        end
      end

      default: begin
        // WRITE, READ_ADD and READ_DATA share the shift-in path.
        if (bus.SS_n) begin
          // Deselect: drop any partial frame or shift-out, keep rd_addr_flag.
          state_next      = IDLE;
          bit_cnt_next    = '0;
          frame_done_next = 1'b0;
          tx_shift_next   = '0;
          tx_cnt_next     = '0;
          tx_busy_next    = 1'b0;
          tx_done_next    = 1'b0;
`ifdef SPI_SLAVE_ABORT_FLAG_EN
          abort_next = !frame_done_reg ||
                       ((state_reg == READ_DATA) && !tx_done_reg);
`endif
        end else if (!frame_done_reg) begin
          rx_shift_next = {rx_shift_reg[FRAME_W-3:0], bus.MOSI};
          if (bit_cnt_reg == LAST_BIT) begin
            rx_data_next    = {rx_shift_reg, bus.MOSI};
            rx_valid_next   = 1'b1;
            frame_done_next = 1'b1;
            bit_cnt_next    = '0;
            // The state, not the received command bits, decides the flag.
            if (state_reg == READ_ADD) begin
              rd_addr_flag_next = 1'b1;
            end else if (state_reg == READ_DATA) begin
              rd_addr_flag_next = 1'b0;
            end
          end else begin
            bit_cnt_next = bit_cnt_reg + 1'b1;
          end
        end else if (state_reg == READ_DATA) begin
          if (tx_busy_reg) begin
            if (tx_cnt_reg != '0) begin
              miso_next     = tx_shift_reg[ADDR_SIZE-1];
              tx_shift_next = tx_shift_reg << 1;
              tx_cnt_next   = tx_cnt_reg - 1'b1;
            end else begin
              // Last bit has been on MISO for its cycle; release the line.
              tx_busy_next = 1'b0;
              tx_done_next = 1'b1;
            end
          end else if (!tx_done_reg && bus.tx_valid) begin
            // Capture the read word and put its MSB out on the very next cycle.
            miso_next     = bus.tx_data[ADDR_SIZE-1];
            tx_shift_next = bus.tx_data << 1;
            tx_cnt_next   = TX_LAST;
            tx_busy_next  = 1'b1;
          end
        end
      end
    endcase
  end

  assign bus.MISO     = miso_reg;
  assign bus.rx_data  = rx_data_reg;
  assign bus.rx_valid = rx_valid_reg;
`ifdef SPI_SLAVE_ABORT_FLAG_EN
  assign frame_abort  = abort_reg;
`endif

endmodule

// File: tb/tb_spi_slave_if.sv
// Directed bench for spi_slave_if: a table of complete frames (select bit,
// command word, read word offered back, expected rx_data and MISO word),
// plus hand-written reset, abort and mid-shift reset sequences.
module tb_spi_slave_if;

  localparam int AW = 8;

  logic clk = 1'b0;
  logic rst_n;
`ifdef SPI_SLAVE_ABORT_FLAG_EN
  logic frame_abort;
`endif

  spi_slave_if_if #(.ADDR_SIZE(AW)) bus ();

  spi_slave_if #(.ADDR_SIZE(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef SPI_SLAVE_ABORT_FLAG_EN
    ,
    .frame_abort (frame_abort)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int rx_pulses = 0;

  // Count rx_valid pulses independently of the directed checks.
  always @(negedge clk) begin
    if (bus.rx_valid === 1'b1) rx_pulses++;
  end

  typedef struct {
    logic       sel;
    logic [9:0] frame;
    logic [7:0] tx;
    logic [9:0] exp_rx;
    logic [7:0] exp_miso;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Select, then 10 frame bits MSB first; returns right after bit 0 is driven.
  task automatic send_frame(input logic sel, input logic [9:0] frame);
    @(negedge clk);
    bus.SS_n = 1'b0;
    @(negedge clk);
    bus.MOSI = sel;
    for (int i = 9; i >= 0; i--) begin
      @(negedge clk);
      bus.MOSI = frame[i];
    end
  endtask

  // Full transaction: frame, rx checks, tx_valid offer, MISO capture, deselect.
  task automatic do_frame(input logic sel, input logic [9:0] frame, input logic [7:0] tx,
                          input logic [9:0] exp_rx, input logic [7:0] exp_miso);
    int start;
    logic [7:0] got;
    start = rx_pulses;
    send_frame(sel, frame);
    @(negedge clk);
    check("rx_valid_pulse", 32'(bus.rx_valid), 32'(1));
    check("rx_data", 32'(bus.rx_data), 32'(exp_rx));
    bus.MOSI = ~bus.MOSI;
    @(negedge clk);
    check("rx_valid_single", 32'(bus.rx_valid), 32'(0));
    bus.tx_valid = 1'b1;
    bus.tx_data  = tx;
    bus.MOSI     = ~bus.MOSI;
    @(negedge clk);
    bus.tx_valid = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      got[i] = bus.MISO;
      @(negedge clk);
      bus.MOSI = ~bus.MOSI;
    end
    check("miso_word", 32'(got), 32'(exp_miso));
    check("miso_idle_after", 32'(bus.MISO), 32'(0));
    bus.SS_n = 1'b1;
    @(negedge clk);
    check("rx_pulse_count", 32'(rx_pulses - start), 32'(1));
    check("miso_deselected", 32'(bus.MISO), 32'(0));
    $display("frame sel=%0d word=%h rx_data=%h miso=%h", sel, frame, bus.rx_data, got);
  endtask

  initial begin
    vecs[0] = '{1'b0, 10'h0A5, 8'h55, 10'h0A5, 8'h00}; // write address
    vecs[1] = '{1'b0, 10'h1F0, 8'hAA, 10'h1F0, 8'h00}; // write data
    vecs[2] = '{1'b1, 10'h203, 8'h3C, 10'h203, 8'h00}; // read address -> flag=1
    vecs[3] = '{1'b1, 10'h300, 8'hC3, 10'h300, 8'hC3}; // read data -> shift out, flag=0
    vecs[4] = '{1'b1, 10'h2A7, 8'hFF, 10'h2A7, 8'h00}; // read address -> flag=1
    vecs[5] = '{1'b0, 10'h155, 8'h11, 10'h155, 8'h00}; // write keeps flag
    vecs[6] = '{1'b1, 10'h3FF, 8'h81, 10'h3FF, 8'h81}; // read data after write
    vecs[7] = '{1'b1, 10'h200, 8'h7E, 10'h200, 8'h00}; // read address
    vecs[8] = '{1'b1, 10'h3AB, 8'h5A, 10'h3AB, 8'h5A}; // read data, rx[9:8] passed through

    // Reset held with the slave selected and MOSI toggling.
    rst_n        = 1'b0;
    bus.SS_n     = 1'b0;
    bus.MOSI     = 1'b0;
    bus.tx_valid = 1'b0;
    bus.tx_data  = '0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("reset_miso", 32'(bus.MISO), 32'(0));
      check("reset_rx_valid", 32'(bus.rx_valid), 32'(0));
      check("reset_rx_data", 32'(bus.rx_data), 32'(0));
      bus.MOSI = ~bus.MOSI;
    end
    bus.SS_n = 1'b1;
    rst_n    = 1'b1;
    repeat (2) @(negedge clk);
    check("post_reset_rx_valid", 32'(bus.rx_valid), 32'(0));
`ifdef SPI_SLAVE_ABORT_FLAG_EN
    check("post_reset_abort", 32'(frame_abort), 32'(0));
`endif

    for (int v = 0; v < 9; v++) begin
      do_frame(vecs[v].sel, vecs[v].frame, vecs[v].tx, vecs[v].exp_rx, vecs[v].exp_miso);
    end

    // Abort a write after 4 of 10 bits: no rx_valid, rx_data keeps the old frame.
    begin
      int start;
      start = rx_pulses;
      @(negedge clk);
      bus.SS_n = 1'b0;
      @(negedge clk);
      bus.MOSI = 1'b0;
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        bus.MOSI = ~bus.MOSI;
      end
      @(negedge clk);
      bus.SS_n = 1'b1;
      @(negedge clk);
      check("abort_no_rx_valid", 32'(bus.rx_valid), 32'(0));
`ifdef SPI_SLAVE_ABORT_FLAG_EN
      check("abort_pulse", 32'(frame_abort), 32'(1));
`endif
      @(negedge clk);
`ifdef SPI_SLAVE_ABORT_FLAG_EN
      check("abort_pulse_end", 32'(frame_abort), 32'(0));
`endif
      check("abort_rx_count", 32'(rx_pulses - start), 32'(0));
      check("abort_rx_data_held", 32'(bus.rx_data), 32'(10'h3AB));
      $display("abort write after 4 bits rx_data=%h", bus.rx_data);
    end
    // A frame straight after the abort proves the FSM went back to IDLE.
    do_frame(1'b0, 10'h0C6, 8'h99, 10'h0C6, 8'h00);

    // Aborted READ_DATA must keep rd_addr_flag set.
    do_frame(1'b1, 10'h2A7, 8'h00, 10'h2A7, 8'h00);
    @(negedge clk);
    bus.SS_n = 1'b0;
    @(negedge clk);
    bus.MOSI = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.MOSI = 1'b1;
    end
    @(negedge clk);
    bus.SS_n = 1'b1;
    @(negedge clk);
`ifdef SPI_SLAVE_ABORT_FLAG_EN
    check("abort_read_pulse", 32'(frame_abort), 32'(1));
`endif
    check("abort_read_no_rx_valid", 32'(bus.rx_valid), 32'(0));
    $display("abort read-data after 3 bits");
    do_frame(1'b1, 10'h3C5, 8'h96, 10'h3C5, 8'h96);

    // Async reset in the middle of shifting out 8'hFF.
    do_frame(1'b1, 10'h211, 8'h00, 10'h211, 8'h00);
    send_frame(1'b1, 10'h3FF);
    @(negedge clk);
    check("rst_seq_rx_valid", 32'(bus.rx_valid), 32'(1));
    @(negedge clk);
    bus.tx_valid = 1'b1;
    bus.tx_data  = 8'hFF;
    @(negedge clk);
    bus.tx_valid = 1'b0;
    check("rst_seq_miso_b7", 32'(bus.MISO), 32'(1));
    @(negedge clk);
    check("rst_seq_miso_b6", 32'(bus.MISO), 32'(1));
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_miso", 32'(bus.MISO), 32'(0));
    check("async_reset_rx_data", 32'(bus.rx_data), 32'(0));
    $display("async reset during shift-out of ff");
    @(negedge clk);
    bus.SS_n = 1'b1;
    rst_n    = 1'b1;
    @(negedge clk);
    // Flag was cleared by reset, so this read frame is an address frame.
    do_frame(1'b1, 10'h3AB, 8'h5A, 10'h3AB, 8'h00);
    do_frame(1'b1, 10'h300, 8'hC3, 10'h300, 8'hC3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
